// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file -- machine-mode CSR unit for the NPC core (EXU/WBU boundary).
//
// Decodes 12-bit CSR addresses and performs CSRRW/CSRRS/CSRRC atomically.
// It also handles trap entry and mret, including the mstatus MIE/MPIE
// stack, and supplies the trap and return PCs to the IFU redirect path.
//
// Optional feature macro: CSR_COUNTERS_EN
//   defined   : mcycle (0xB00) and minstret (0xB02) exist. With XLEN=32,
//               0xB80/0xB82 expose the upper halves of the 64-bit counters.
//   undefined : these addresses are unimplemented and no counter flops exist.
//
// Parameters:
//   XLEN        data width of every CSR and PC (32 or 64)
//   CAUSE_W     width of the exception code driven in
//   RESET_MTVEC reset value of mtvec
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   csr_addr     CSR address of the current access
//   csr_op       00 none, 01 write, 10 set, 11 clear
//   csr_wdata    operand (rs1 or zero-extended zimm)
//   csr_rdata    pre-write value of the addressed CSR (combinational)
//   csr_illegal  access (csr_op!=00) to an unimplemented address
//   exception    trap request this cycle
//   exc_irq      trap is an interrupt
//   exc_epc      PC of the faulting instruction
//   exc_cause    exception code
//   mret         mret retiring this cycle
//   instret_inc  one instruction retired this cycle
//   trap_pc      trap vector target
//   ret_pc       mepc with bits [1:0] cleared
//   global_ie    mstatus.MIE
// ---------------------------------------------------------------------------
module csr_file #(
  parameter int              XLEN        = 64,
  parameter int              CAUSE_W     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic               exception,
  input  logic               exc_irq,
  input  logic [XLEN-1:0]    exc_epc,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic               mret,
  input  logic               instret_inc,
  output logic [XLEN-1:0]    trap_pc,
  output logic [XLEN-1:0]    ret_pc,
  output logic               global_ie
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Read-only part of mstatus: MPP=11 always, and on RV64 SXL/UXL=2.
  localparam logic [63:0] MSTATUS_FIXED_64 = (XLEN == 64) ? 64'h0000_000a_0000_1800
                                                          : 64'h0000_0000_0000_1800;
  localparam logic [XLEN-1:0] MSTATUS_FIXED = MSTATUS_FIXED_64[XLEN-1:0];

  // Architectural state. mstatus only stores its two writable bits.
  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;

  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic            w_hit;
  logic            w_wr_en;
  logic [XLEN-1:0] w_trap_cause;
  logic [XLEN-1:0] w_base;

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam bit          HAS_HI         = (XLEN == 32);
  // Bits of the 64-bit counter that the low-half address covers.
  localparam logic [63:0] LO_MASK = (XLEN == 64) ? 64'hffff_ffff_ffff_ffff
                                                 : 64'h0000_0000_ffff_ffff;

  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic [63:0] w_new64;
  logic        w_wr_mcycle;
  logic        w_wr_mcycleh;
  logic        w_wr_minstret;
  logic        w_wr_minstreth;
`endif

  always_comb begin
    w_mstatus    = MSTATUS_FIXED;
    w_mstatus[7] = r_mpie;
    w_mstatus[3] = r_mie;
  end

  // Address decode and pre-write read value.
  always_comb begin
    w_hit = 1'b1;
    w_old = '0;
    case (csr_addr)
      ADDR_MSTATUS:  w_old = w_mstatus;
      ADDR_MTVEC:    w_old = r_mtvec;
      ADDR_MSCRATCH: w_old = r_mscratch;
      ADDR_MEPC:     w_old = r_mepc;
      ADDR_MCAUSE:   w_old = r_mcause;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:   w_old = r_mcycle[XLEN-1:0];
      ADDR_MINSTRET: w_old = r_minstret[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (HAS_HI) w_old = XLEN'(r_mcycle[63:32]);
        else        w_hit = 1'b0;
      end
      ADDR_MINSTRETH: begin
        if (HAS_HI) w_old = XLEN'(r_minstret[63:32]);
        else        w_hit = 1'b0;
      end
`endif
      default:       w_hit = 1'b0;
    endcase
  end

  // Read-modify-write result; masking per register happens at the write.
  always_comb begin
    case (csr_op)
      OP_WRITE: w_new = csr_wdata;
      OP_SET:   w_new = w_old | csr_wdata;
      OP_CLEAR: w_new = w_old & ~csr_wdata;
      default:  w_new = w_old;
    endcase
  end

  assign csr_rdata   = w_old;
  assign csr_illegal = (csr_op != OP_NONE) && !w_hit;
  // A trap or mret in the same cycle swallows the CSR write entirely.
  assign w_wr_en     = (csr_op != OP_NONE) && w_hit && !exception && !mret;

  always_comb begin
    w_trap_cause                = '0;
    w_trap_cause[CAUSE_W-1:0]   = exc_cause;
    w_trap_cause[XLEN-1]        = exc_irq;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= RESET_MTVEC;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else if (exception) begin
      r_mepc   <= {exc_epc[XLEN-1:2], 2'b00};
      r_mcause <= w_trap_cause;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr_en) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          r_mie  <= w_new[3];
          r_mpie <= w_new[7];
        end
        // MODE is limited to 0/1, so bit 1 never sticks.
        ADDR_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2], 1'b0, w_new[0]};
        ADDR_MSCRATCH: r_mscratch <= w_new;
        ADDR_MEPC:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
        ADDR_MCAUSE:   r_mcause   <= w_new;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  assign w_new64        = 64'(w_new);
  assign w_wr_mcycle    = w_wr_en && (csr_addr == ADDR_MCYCLE);
  assign w_wr_minstret  = w_wr_en && (csr_addr == ADDR_MINSTRET);
  assign w_wr_mcycleh   = w_wr_en && HAS_HI && (csr_addr == ADDR_MCYCLEH);
  assign w_wr_minstreth = w_wr_en && HAS_HI && (csr_addr == ADDR_MINSTRETH);

  // A write lands exactly and replaces that cycle's increment; traps and
  // mret never stall counting (they only drop the write via w_wr_en).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wr_mcycle)
        r_mcycle <= (r_mcycle & ~LO_MASK) | (w_new64 & LO_MASK);
      else if (w_wr_mcycleh)
        r_mcycle <= (r_mcycle & LO_MASK) | (w_new64 << 32);
      else
        r_mcycle <= r_mcycle + 64'd1;

      if (w_wr_minstret)
        r_minstret <= (r_minstret & ~LO_MASK) | (w_new64 & LO_MASK);
      else if (w_wr_minstreth)
        r_minstret <= (r_minstret & LO_MASK) | (w_new64 << 32);
      else if (instret_inc)
        r_minstret <= r_minstret + 64'd1;
    end
  end
`else
  // Retirement pulses have no consumer without the counters.
  logic w_unused_instret;
  assign w_unused_instret = &{1'b0, instret_inc};
`endif

  // Vectored mode only applies to interrupts; held at the base during reset.
  assign w_base    = {r_mtvec[XLEN-1:2], 2'b00};
  assign trap_pc   = (reset && r_mtvec[0] && exc_irq)
                     ? w_base + (XLEN'(exc_cause) << 2)
                     : w_base;
  assign ret_pc    = {r_mepc[XLEN-1:2], 2'b00};
  assign global_ie = r_mie;

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file -- directed, table-driven bench for csr_file (XLEN=64).
// ---------------------------------------------------------------------------
module tb_csr_file;

  localparam logic [63:0] MS   = 64'h0000_000a_0000_1800;
  localparam logic [63:0] ONES = 64'hffff_ffff_ffff_ffff;
  localparam int          NV   = 43;

  logic        clock;
  logic        reset;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        exception;
  logic        exc_irq;
  logic [63:0] exc_epc;
  logic [3:0]  exc_cause;
  logic        mret;
  logic        instret_inc;
  logic [63:0] trap_pc;
  logic [63:0] ret_pc;
  logic        global_ie;

  int n_cmp = 0;
  int n_bad = 0;

  csr_file dut (
    .clock       (clock),
    .reset       (reset),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .exception   (exception),
    .exc_irq     (exc_irq),
    .exc_epc     (exc_epc),
    .exc_cause   (exc_cause),
    .mret        (mret),
    .instret_inc (instret_inc),
    .trap_pc     (trap_pc),
    .ret_pc      (ret_pc),
    .global_ie   (global_ie)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [63:0] wdata;
    logic        exc;
    logic        irq;
    logic [63:0] epc;
    logic [3:0]  cause;
    logic        mret;
    logic [63:0] exp_rdata;
    logic        exp_ill;
    logic        exp_ie;
    logic [63:0] exp_ret;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic [11:0] addr, input logic [1:0] op,
                              input logic [63:0] wdata, input logic exc,
                              input logic irq, input logic [63:0] epc,
                              input logic [3:0] cause, input logic mr,
                              input logic [63:0] rd, input logic ill,
                              input logic ie, input logic [63:0] ret);
    vec_t v;
    v.addr = addr; v.op = op; v.wdata = wdata; v.exc = exc; v.irq = irq;
    v.epc = epc; v.cause = cause; v.mret = mr; v.exp_rdata = rd;
    v.exp_ill = ill; v.exp_ie = ie; v.exp_ret = ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    csr_addr = 12'h000; csr_op = 2'b00; csr_wdata = '0;
    exception = 1'b0; exc_irq = 1'b0; exc_epc = '0; exc_cause = '0;
    mret = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    csr_addr = v.addr; csr_op = v.op; csr_wdata = v.wdata;
    exception = v.exc; exc_irq = v.irq; exc_epc = v.epc; exc_cause = v.cause;
    mret = v.mret; instret_inc = 1'b0;
  endtask

  // Advance to just after the next active edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic access(input logic [11:0] a, input logic [1:0] op, input logic [63:0] d);
    idle();
    csr_addr = a; csr_op = op; csr_wdata = d;
  endtask

  initial begin
    //                  addr    op    wdata            exc irq epc                cause mret rdata                  ill ie ret
    vecs[0]  = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS,                    0, 0, 64'h0);
    vecs[1]  = mk(12'h341, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h0,                 0, 0, 64'h0);
    vecs[2]  = mk(12'h340, 2'd1, 64'h1234,       0, 0, 64'h0,            4'd0, 0, 64'h0,                 0, 0, 64'h0);
    vecs[3]  = mk(12'h340, 2'd2, 64'hF0000,      0, 0, 64'h0,            4'd0, 0, 64'h1234,              0, 0, 64'h0);
    vecs[4]  = mk(12'h340, 2'd3, 64'h34,         0, 0, 64'h0,            4'd0, 0, 64'hF1234,             0, 0, 64'h0);
    vecs[5]  = mk(12'h340, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'hF1200,             0, 0, 64'h0);
    vecs[6]  = mk(12'h340, 2'd2, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'hF1200,             0, 0, 64'h0);
    vecs[7]  = mk(12'h340, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'hF1200,             0, 0, 64'h0);
    vecs[8]  = mk(12'h300, 2'd1, 64'h8,          0, 0, 64'h0,            4'd0, 0, MS,                    0, 0, 64'h0);
    vecs[9]  = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS | 64'h8,            0, 1, 64'h0);
    vecs[10] = mk(12'h300, 2'd0, 64'h0,          1, 0, 64'h80000007,     4'd2, 0, MS | 64'h8,            0, 1, 64'h0);
    vecs[11] = mk(12'h341, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h80000004,          0, 0, 64'h80000004);
    vecs[12] = mk(12'h342, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h2,                 0, 0, 64'h80000004);
    vecs[13] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS | 64'h80,           0, 0, 64'h80000004);
    vecs[14] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 1, MS | 64'h80,           0, 0, 64'h80000004);
    vecs[15] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS | 64'h88,           0, 1, 64'h80000004);
    vecs[16] = mk(12'h300, 2'd3, 64'h88,         0, 0, 64'h0,            4'd0, 0, MS | 64'h88,           0, 1, 64'h80000004);
    vecs[17] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS,                    0, 0, 64'h80000004);
    vecs[18] = mk(12'h300, 2'd1, ONES,           0, 0, 64'h0,            4'd0, 0, MS,                    0, 0, 64'h80000004);
    vecs[19] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS | 64'h88,           0, 1, 64'h80000004);
    vecs[20] = mk(12'h300, 2'd1, 64'h80,         0, 0, 64'h0,            4'd0, 0, MS | 64'h88,           0, 1, 64'h80000004);
    vecs[21] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS | 64'h80,           0, 0, 64'h80000004);
    vecs[22] = mk(12'h341, 2'd1, 64'h1237,       0, 0, 64'h0,            4'd0, 0, 64'h80000004,          0, 0, 64'h80000004);
    vecs[23] = mk(12'h341, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h1234,              0, 0, 64'h1234);
    vecs[24] = mk(12'h305, 2'd1, ONES,           0, 0, 64'h0,            4'd0, 0, 64'h0,                 0, 0, 64'h1234);
    vecs[25] = mk(12'h305, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'hffff_ffff_ffff_fffd, 0, 0, 64'h1234);
    vecs[26] = mk(12'h342, 2'd1, 64'h55,         0, 0, 64'h0,            4'd0, 0, 64'h2,                 0, 0, 64'h1234);
    vecs[27] = mk(12'h342, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h55,                0, 0, 64'h1234);
    vecs[28] = mk(12'h7C0, 2'd1, 64'h5,          0, 0, 64'h0,            4'd0, 0, 64'h0,                 1, 0, 64'h1234);
    vecs[29] = mk(12'h7C0, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h0,                 0, 0, 64'h1234);
    vecs[30] = mk(12'h301, 2'd3, 64'h1,          0, 0, 64'h0,            4'd0, 0, 64'h0,                 1, 0, 64'h1234);
    vecs[31] = mk(12'h340, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'hF1200,             0, 0, 64'h1234);
    vecs[32] = mk(12'h300, 2'd1, 64'h8,          0, 0, 64'h0,            4'd0, 0, MS | 64'h80,           0, 0, 64'h1234);
    vecs[33] = mk(12'h341, 2'd1, 64'h55,         1, 0, 64'h2003,         4'd5, 1, 64'h1234,              0, 1, 64'h1234);
    vecs[34] = mk(12'h341, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h2000,              0, 0, 64'h2000);
    vecs[35] = mk(12'h342, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h5,                 0, 0, 64'h2000);
    vecs[36] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS | 64'h80,           0, 0, 64'h2000);
    vecs[37] = mk(12'h340, 2'd1, 64'h0,          0, 0, 64'h0,            4'd0, 1, 64'hF1200,             0, 0, 64'h2000);
    vecs[38] = mk(12'h340, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'hF1200,             0, 1, 64'h2000);
    vecs[39] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS | 64'h88,           0, 1, 64'h2000);
    vecs[40] = mk(12'h300, 2'd3, 64'h88,         1, 1, 64'h3000,         4'd3, 0, MS | 64'h88,           0, 1, 64'h2000);
    vecs[41] = mk(12'h300, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, MS | 64'h80,           0, 0, 64'h3000);
    vecs[42] = mk(12'h342, 2'd0, 64'h0,          0, 0, 64'h0,            4'd0, 0, 64'h8000_0000_0000_0003, 0, 0, 64'h3000);

    // ---------------- reset state ----------------
    idle();
    reset = 1'b0;
    csr_addr = 12'h300;
    @(negedge clock);
    check("rst mstatus", csr_rdata, MS);
    check("rst trap_pc", trap_pc, 64'h0);
    check("rst ret_pc", ret_pc, 64'h0);
    check("rst global_ie", {63'd0, global_ie}, 64'h0);
    csr_addr = 12'h7C0; csr_op = 2'd1;
    #1;
    check("rst illegal", {63'd0, csr_illegal}, 64'h1);
    idle();
    @(negedge clock);
    reset = 1'b1;
    cycle();

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(negedge clock);
      check($sformatf("v%0d rdata", i), csr_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d illegal", i), {63'd0, csr_illegal}, {63'd0, vecs[i].exp_ill});
      check($sformatf("v%0d global_ie", i), {63'd0, global_ie}, {63'd0, vecs[i].exp_ie});
      check($sformatf("v%0d ret_pc", i), ret_pc, vecs[i].exp_ret);
      $display("vec %0d addr=%03h op=%0d exc=%0d mret=%0d rdata=%016h ill=%0d ie=%0d",
               i, vecs[i].addr, vecs[i].op, vecs[i].exc, vecs[i].mret,
               csr_rdata, csr_illegal, global_ie);
      cycle();
    end

    // ---------------- trap_pc vectoring ----------------
    access(12'h305, 2'd1, 64'h80001003);
    cycle();
    access(12'h305, 2'd0, 64'h0);
    exc_irq = 1'b1; exc_cause = 4'd7;
    @(negedge clock);
    check("mtvec bit1 forced", csr_rdata, 64'h80001001);
    check("trap_pc vectored irq", trap_pc, 64'h8000101C);
    exc_irq = 1'b0;
    #1;
    check("trap_pc vectored exc", trap_pc, 64'h80001000);
    $display("seq trap_pc: mtvec=%016h trap_pc=%016h", csr_rdata, trap_pc);
    cycle();
    idle();
    exception = 1'b1; exc_irq = 1'b1; exc_cause = 4'd7; exc_epc = 64'h4002;
    cycle();
    access(12'h342, 2'd0, 64'h0);
    @(negedge clock);
    check("mcause irq", csr_rdata, 64'h8000_0000_0000_0007);
    check("mepc irq", ret_pc, 64'h4000);
    $display("seq irq trap: mcause=%016h mepc=%016h", csr_rdata, ret_pc);
    cycle();
    access(12'h305, 2'd1, 64'h80001000);
    cycle();
    idle();
    exc_irq = 1'b1; exc_cause = 4'd7;
    @(negedge clock);
    check("trap_pc direct irq", trap_pc, 64'h80001000);
    cycle();

    // ---------------- counters ----------------
`ifdef CSR_COUNTERS_EN
    access(12'hB00, 2'd1, 64'hffff_ffff_ffff_fffe);
    cycle();
    access(12'hB00, 2'd0, 64'h0);
    @(negedge clock);
    check("mcycle written", csr_rdata, 64'hffff_ffff_ffff_fffe);
    check("mcycle legal", {63'd0, csr_illegal}, 64'h0);
    cycle();
    @(negedge clock);
    check("mcycle +1", csr_rdata, 64'hffff_ffff_ffff_ffff);
    cycle();
    @(negedge clock);
    check("mcycle wrap", csr_rdata, 64'h0);
    $display("seq mcycle wrap: mcycle=%016h", csr_rdata);
    cycle();
    access(12'hB02, 2'd1, 64'h5);
    instret_inc = 1'b1;
    cycle();
    access(12'hB02, 2'd0, 64'h0);
    instret_inc = 1'b1; exception = 1'b1; exc_epc = 64'h100;
    @(negedge clock);
    check("minstret write wins", csr_rdata, 64'h5);
    cycle();
    access(12'hB02, 2'd0, 64'h0);
    @(negedge clock);
    check("minstret counts in trap", csr_rdata, 64'h6);
    cycle();
    @(negedge clock);
    check("minstret holds", csr_rdata, 64'h6);
    $display("seq minstret: minstret=%016h", csr_rdata);
    cycle();
`else
    access(12'hB00, 2'd2, 64'h1);
    @(negedge clock);
    check("no mcycle illegal", {63'd0, csr_illegal}, 64'h1);
    check("no mcycle rdata", csr_rdata, 64'h0);
    cycle();
    access(12'hB82, 2'd1, 64'h1);
    @(negedge clock);
    check("no minstreth illegal", {63'd0, csr_illegal}, 64'h1);
    $display("seq no counters: ill=%0d rdata=%016h", csr_illegal, csr_rdata);
    cycle();
`endif

    // ---------------- asynchronous reset mid-run ----------------
    access(12'h340, 2'd1, 64'hABCD);
    cycle();
    access(12'h340, 2'd1, 64'h9999);
    #2;
    reset = 1'b0;
    #1;
    check("mid rst mscratch", csr_rdata, 64'h0);
    check("mid rst trap_pc", trap_pc, 64'h0);
    check("mid rst ret_pc", ret_pc, 64'h0);
    check("mid rst global_ie", {63'd0, global_ie}, 64'h0);
    csr_addr = 12'h300; csr_op = 2'd0;
    #1;
    check("mid rst mstatus", csr_rdata, MS);
`ifdef CSR_COUNTERS_EN
    csr_addr = 12'hB00;
    #1;
    check("mid rst mcycle", csr_rdata, 64'h0);
`endif
    $display("seq async reset: mstatus=%016h trap_pc=%016h", csr_rdata, trap_pc);
    cycle();
    idle();
    @(negedge clock);
    reset = 1'b1;
    cycle();
    access(12'h340, 2'd0, 64'h0);
    @(negedge clock);
    check("post rst mscratch", csr_rdata, 64'h0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
